lsq_inorder: RTL and testbench

- Parametrised, in-order load/store queue that replaces the single-entry load/store path.
- Accepts memory ops from dispatch and buffers them in a DEPTH-entry circular queue.
- Captures missing base/store-data operands from NUM_BCAST ALU broadcast channels.
- Issues the head entry to the dcache port, sign- or zero-extends load data and broadcasts load results and store completions back to the ROB and issue queues.

---
 rtl/lsq_inorder_pkg.sv | 41 ++++
 rtl/lsq_inorder_if.sv | 41 ++++
 rtl/lsq_inorder_align.sv | 43 ++++
 rtl/lsq_inorder.sv | 161 ++++++++++++++++
 tb/tb_lsq_inorder.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsq_inorder_pkg.sv
// rtl/lsq_inorder_pkg.sv - shared types, funct3 codes and address generation for the load/store queue
package lsq_pkg;

  localparam int LSQ_XLEN     = 32;
  localparam int LSQ_ROB_ID_W = 5;

  typedef logic [LSQ_ROB_ID_W-1:0] rob_id_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsq_state_t;

  typedef struct packed {
    rob_id_t               rob_id;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [11:0]           imm;
    logic                  base_rdy;
    rob_id_t               base_tag;
    logic [LSQ_XLEN-1:0]   base_val;
    logic                  sdata_rdy;
    rob_id_t               sdata_tag;
    logic [LSQ_XLEN-1:0]   sdata_val;
  } lsq_dispatch_t;

  typedef struct packed {
    logic                  valid;
    lsq_dispatch_t         op;
    logic [LSQ_XLEN-1:0]   addr;
  } lsq_entry_t;

  function automatic logic [LSQ_XLEN-1:0] lsq_agen(input logic [LSQ_XLEN-1:0] base,
                                                   input logic [11:0] imm);
    return base + {{(LSQ_XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/lsq_inorder_if.sv
// rtl/lsq_inorder_if.sv - dispatch, ALU wakeup, dcache and completion signals of the load/store queue
interface lsq_inorder_if import lsq_pkg::*; #(
  parameter int XLEN      = LSQ_XLEN,
  parameter int ROB_ID_W  = LSQ_ROB_ID_W,
  parameter int NUM_BCAST = 2
);

  logic                          dispatch_valid;
  logic                          dispatch_ready;
  lsq_dispatch_t                 dispatch_data;
  logic [NUM_BCAST-1:0]          alu_bcast_valid;
  logic [NUM_BCAST*ROB_ID_W-1:0] alu_bcast_rob_id;
  logic [NUM_BCAST*XLEN-1:0]     alu_bcast_data;
  logic                          dc_req_valid;
  logic                          dc_req_ready;
  logic                          dc_req_is_st;
  logic [XLEN-1:0]               dc_req_addr;
  logic [XLEN-1:0]               dc_req_wdata;
  logic [XLEN/8-1:0]             dc_req_wmask;
  logic                          dc_resp_valid;
  logic [XLEN-1:0]               dc_resp_data;
  logic                          lsu_bcast_valid;
  logic [ROB_ID_W-1:0]           lsu_bcast_rob_id;
  logic [XLEN-1:0]               lsu_bcast_data;

  // master is the surrounding core/dcache side, slave is the queue itself
  modport master (
    output dispatch_valid, dispatch_data, alu_bcast_valid, alu_bcast_rob_id, alu_bcast_data,
           dc_req_ready, dc_resp_valid, dc_resp_data,
    input  dispatch_ready, dc_req_valid, dc_req_is_st, dc_req_addr, dc_req_wdata, dc_req_wmask,
           lsu_bcast_valid, lsu_bcast_rob_id, lsu_bcast_data
  );

  modport slave (
    input  dispatch_valid, dispatch_data, alu_bcast_valid, alu_bcast_rob_id, alu_bcast_data,
           dc_req_ready, dc_resp_valid, dc_resp_data,
    output dispatch_ready, dc_req_valid, dc_req_is_st, dc_req_addr, dc_req_wdata, dc_req_wmask,
           lsu_bcast_valid, lsu_bcast_rob_id, lsu_bcast_data
  );

endinterface

// File: rtl/lsq_inorder_align.sv
// rtl/lsq_inorder_align.sv - load data extraction and store lane/byte-enable generation
module lsq_align import lsq_pkg::*; #(
  parameter int XLEN = LSQ_XLEN
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   resp_data,
  input  logic [XLEN-1:0]   sdata,
  output logic [XLEN-1:0]   load_data,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] wmask
);

  localparam logic [XLEN/8-1:0] MASK_B = (XLEN/8)'(1);
  localparam logic [XLEN/8-1:0] MASK_H = (XLEN/8)'(3);

  logic [4:0]      lane_shift;
  logic [XLEN-1:0] shifted;

  assign lane_shift = {addr_lo, 3'b000};
  assign shifted    = resp_data >> lane_shift;
  assign wdata      = sdata << lane_shift;

  always_comb begin
    case (funct3)
      LS_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LS_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LS_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LS_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LS_W:    load_data = shifted;
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    case (funct3)
      LS_B:    wmask = MASK_B << addr_lo;
      LS_H:    wmask = MASK_H << addr_lo;
      default: wmask = '1;
    endcase
  end

endmodule

// File: rtl/lsq_inorder.sv
// rtl/lsq_inorder.sv - in-order load/store queue: operand wakeup, head issue to dcache, completion broadcast
module lsq_inorder import lsq_pkg::*; #(
  parameter int DEPTH     = 8,
  parameter int XLEN      = LSQ_XLEN,
  parameter int ROB_ID_W  = LSQ_ROB_ID_W,
  parameter int NUM_BCAST = 2
) (
  input  logic         clk,
  input  logic         rst_aL,
  lsq_inorder_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]   head_ptr, tail_ptr;
  logic [IW-1:0]   head_idx, tail_idx;
  lsq_entry_t      entries [DEPTH];
  lsq_entry_t      woken   [DEPTH];
  lsq_entry_t      disp_raw, disp_entry;
  rob_id_t         bc_tag  [NUM_BCAST];
  logic [XLEN-1:0] bc_data [NUM_BCAST];
  lsq_state_t      state, state_nxt;
  logic            full, push, pop, head_ready;
  logic [XLEN-1:0] result, load_data, st_wdata;
  logic [XLEN/8-1:0] st_wmask;

  always_comb begin
    for (int c = 0; c < NUM_BCAST; c++) begin
      bc_tag[c]  = bus.alu_bcast_rob_id[c*ROB_ID_W +: ROB_ID_W];
      bc_data[c] = bus.alu_bcast_data[c*XLEN +: XLEN];
    end
  end

  // scanning from the top down leaves the lowest matching channel as the winner
  function automatic void snoop(input rob_id_t tag, output logic hit, output logic [XLEN-1:0] val);
    hit = 1'b0;
    val = '0;
    for (int c = NUM_BCAST-1; c >= 0; c--) begin
      if (bus.alu_bcast_valid[c] && bc_tag[c] == tag) begin
        hit = 1'b1;
        val = bc_data[c];
      end
    end
  endfunction

  function automatic lsq_entry_t wake(input lsq_entry_t e);
    lsq_entry_t      w;
    logic            hit;
    logic [XLEN-1:0] val;
    w = e;
    snoop(e.op.base_tag, hit, val);
    if (!e.op.base_rdy && hit) begin
      w.op.base_rdy = 1'b1;
      w.op.base_val = val;
      w.addr        = lsq_agen(val, e.op.imm);
    end
    snoop(e.op.sdata_tag, hit, val);
    if (!e.op.sdata_rdy && hit) begin
      w.op.sdata_rdy = 1'b1;
      w.op.sdata_val = val;
    end
    return w;
  endfunction

  assign disp_raw = '{valid: 1'b1, op: bus.dispatch_data,
                      addr: lsq_agen(bus.dispatch_data.base_val, bus.dispatch_data.imm)};
  assign disp_entry = wake(disp_raw);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) woken[i] = wake(entries[i]);
  end

  assign head_idx = head_ptr[IW-1:0];
  assign tail_idx = tail_ptr[IW-1:0];
  assign full     = (head_idx == tail_idx) && (head_ptr[IW] != tail_ptr[IW]);
  assign bus.dispatch_ready = !full;
  assign push     = bus.dispatch_valid && !full;
  assign pop      = (state == DONE);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid) entries[i] <= woken[i];
      end
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head_ptr <= head_ptr + PW'(1);
      end
      if (push) begin
        entries[tail_idx] <= disp_entry;
        tail_ptr <= tail_ptr + PW'(1);
      end
    end
  end

  assign head_ready = entries[head_idx].valid && entries[head_idx].op.base_rdy &&
                      (!entries[head_idx].op.is_store || entries[head_idx].op.sdata_rdy);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (head_ready) state_nxt = REQ;
      REQ:  if (bus.dc_req_ready) state_nxt = entries[head_idx].op.is_store ? DONE : WAIT;
      WAIT: if (bus.dc_resp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL)                                result <= '0;
    else if (state == WAIT && bus.dc_resp_valid) result <= load_data;
  end

  lsq_align #(.XLEN(XLEN)) u_align (
    .funct3    (entries[head_idx].op.funct3),
    .addr_lo   (entries[head_idx].addr[1:0]),
    .resp_data (bus.dc_resp_data),
    .sdata     (entries[head_idx].op.sdata_val),
    .load_data (load_data),
    .wdata     (st_wdata),
    .wmask     (st_wmask)
  );

  always_comb begin
    bus.dc_req_valid     = 1'b0;
    bus.dc_req_is_st     = 1'b0;
    bus.dc_req_addr      = '0;
    bus.dc_req_wdata     = '0;
    bus.dc_req_wmask     = '0;
    bus.lsu_bcast_valid  = 1'b0;
    bus.lsu_bcast_rob_id = '0;
    bus.lsu_bcast_data   = '0;
    case (state)
      REQ: begin
        bus.dc_req_valid = 1'b1;
        bus.dc_req_is_st = entries[head_idx].op.is_store;
        bus.dc_req_addr  = entries[head_idx].addr;
        bus.dc_req_wdata = st_wdata;
        bus.dc_req_wmask = st_wmask;
      end
      DONE: begin
        bus.lsu_bcast_valid  = 1'b1;
        bus.lsu_bcast_rob_id = entries[head_idx].op.rob_id;
        bus.lsu_bcast_data   = entries[head_idx].op.is_store ? '0 : result;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsq_inorder.sv
// tb/tb_lsq_inorder.sv - scoreboard bench for lsq_inorder with a randomized dcache responder
module tb_lsq_inorder;
  import lsq_pkg::*;

  localparam int DEPTH = 8;
  localparam int NB    = 2;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  always #5 clk = ~clk;

  lsq_inorder_if #(.XLEN(32), .ROB_ID_W(5), .NUM_BCAST(NB)) bus ();

  lsq_inorder #(.DEPTH(DEPTH), .XLEN(32), .ROB_ID_W(5), .NUM_BCAST(NB)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  rob;
    logic        st;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] base, sdata, resp, e_addr, e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_res;
  } vec_t;

  typedef struct { logic [31:0] addr; logic is_st; logic [31:0] wdata; logic [3:0] wmask; logic [31:0] resp; } req_t;
  typedef struct { logic [4:0] rob; logic [31:0] data; } cpl_t;

  req_t exp_req[$];
  cpl_t exp_cpl[$];
  vec_t vecs[12];
  int n_vec = 0, n_err = 0, n_ops = 0, resp_extra = 0;
  logic pending = 1'b0;
  int pend_cnt = 0;
  logic [31:0] pend_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  function automatic lsq_dispatch_t make_op(input logic [4:0] rob, input logic st, input logic [2:0] f3,
                                            input logic [11:0] imm, input logic brdy, input logic [4:0] btag,
                                            input logic [31:0] bval, input logic srdy, input logic [4:0] stag,
                                            input logic [31:0] sval);
    lsq_dispatch_t d;
    d.rob_id = rob;     d.is_store = st;    d.funct3 = f3;      d.imm = imm;
    d.base_rdy = brdy;  d.base_tag = btag;  d.base_val = bval;
    d.sdata_rdy = srdy; d.sdata_tag = stag; d.sdata_val = sval;
    return d;
  endfunction

  task automatic set_bcast(input logic v0, input logic [4:0] t0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] t1, input logic [31:0] d1);
    bus.alu_bcast_valid  = {v1, v0};
    bus.alu_bcast_rob_id = {t1, t0};
    bus.alu_bcast_data   = {d1, d0};
  endtask

  // called at a negedge; returns at the negedge after the push edge
  task automatic dispatch(input lsq_dispatch_t d);
    int guard = 0;
    bus.dispatch_valid = 1'b1;
    bus.dispatch_data  = d;
    while (!bus.dispatch_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_now("dispatch_timeout");
    else n_ops++;
    @(negedge clk);
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((exp_req.size() != 0 || exp_cpl.size() != 0) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      fail_now({name, "_drain_timeout"});
      exp_req.delete();
      exp_cpl.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // dcache model: random ready, random response latency, stray responses whenever no load is outstanding
  initial begin
    req_t r;
    cpl_t c;
    logic stall_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    bus.dc_req_ready = 1'b0;
    bus.dc_resp_valid = 1'b0;
    bus.dc_resp_data = '0;
    forever begin
      @(negedge clk);
      bus.dc_resp_valid = 1'b0;
      if (!rst_aL) begin
        pending = 1'b0;
        stall_prev = 1'b0;
        bus.dc_req_ready = 1'b0;
      end else begin
        if (pending) begin
          if (pend_cnt == 0) begin
            bus.dc_resp_valid = 1'b1;
            bus.dc_resp_data  = pend_data;
            pending = 1'b0;
          end else pend_cnt--;
        end else if ($urandom_range(0, 2) == 0) begin
          bus.dc_resp_valid = 1'b1;
          bus.dc_resp_data  = 32'hBAD0_BAD0 ^ $urandom;
        end
        if (stall_prev) begin
          check("req_held_valid", bus.dc_req_valid, 1'b1);
          check("req_held_addr", bus.dc_req_addr, addr_prev);
        end
        bus.dc_req_ready = ($urandom_range(0, 3) != 0);
        stall_prev = bus.dc_req_valid && !bus.dc_req_ready;
        addr_prev  = bus.dc_req_addr;
        if (bus.dc_req_valid && bus.dc_req_ready) begin
          if (exp_req.size() == 0) fail_now("unexpected_dc_req");
          else begin
            r = exp_req.pop_front();
            check("req_addr", bus.dc_req_addr, r.addr);
            check("req_is_st", bus.dc_req_is_st, r.is_st);
            if (r.is_st) begin
              check("req_wdata", bus.dc_req_wdata, r.wdata);
              check("req_wmask", bus.dc_req_wmask, r.wmask);
            end else begin
              pending   = 1'b1;
              pend_cnt  = $urandom_range(0, 2) + resp_extra;
              pend_data = r.resp;
            end
          end
        end
        if (bus.lsu_bcast_valid) begin
          if (exp_cpl.size() == 0) fail_now("unexpected_completion");
          else begin
            c = exp_cpl.pop_front();
            check("cpl_rob_id", bus.lsu_bcast_rob_id, c.rob);
            check("cpl_data", bus.lsu_bcast_data, c.data);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

  initial begin
    bus.dispatch_valid = 1'b0;
    bus.dispatch_data  = '0;
    set_bcast(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_aL = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dispatch_ready", bus.dispatch_ready, 1'b1);
    check("rst_dc_req_valid", bus.dc_req_valid, 1'b0);
    check("rst_lsu_bcast_valid", bus.lsu_bcast_valid, 1'b0);
    check("rst_dc_req_addr", bus.dc_req_addr, 32'h0);
    check("rst_lsu_bcast_rob_id", bus.lsu_bcast_rob_id, 5'd0);
    rst_aL = 1'b1;
    @(negedge clk);

    //          rob    st    f3     imm      base          sdata         resp          addr          wdata         wmask  result
    vecs[0]  = '{5'd1, 1'b0, LS_W,   12'h004, 32'h00001000, 32'h0,        32'hDEADBEEF, 32'h00001004, 32'h0,        4'h0, 32'hDEADBEEF};
    vecs[1]  = '{5'd2, 1'b0, LS_B,   12'h003, 32'h00001000, 32'h0,        32'h80FF0000, 32'h00001003, 32'h0,        4'h0, 32'hFFFFFF80};
    vecs[2]  = '{5'd3, 1'b0, LS_BU,  12'h003, 32'h00001000, 32'h0,        32'h80FF0000, 32'h00001003, 32'h0,        4'h0, 32'h00000080};
    vecs[3]  = '{5'd4, 1'b0, LS_H,   12'h002, 32'h00002000, 32'h0,        32'h80011234, 32'h00002002, 32'h0,        4'h0, 32'hFFFF8001};
    vecs[4]  = '{5'd5, 1'b0, LS_HU,  12'h002, 32'h00002000, 32'h0,        32'h80011234, 32'h00002002, 32'h0,        4'h0, 32'h00008001};
    vecs[5]  = '{5'd6, 1'b1, LS_B,   12'h001, 32'h00003000, 32'h000000AB, 32'h0,        32'h00003001, 32'h0000AB00, 4'h2, 32'h0};
    vecs[6]  = '{5'd7, 1'b1, LS_W,   12'hFFC, 32'h00003000, 32'h12345678, 32'h0,        32'h00002FFC, 32'h12345678, 4'hF, 32'h0};
    vecs[7]  = '{5'd8, 1'b0, LS_B,   12'h801, 32'h00001000, 32'h0,        32'h00007F00, 32'h00000801, 32'h0,        4'h0, 32'h0000007F};
    vecs[8]  = '{5'd9, 1'b0, LS_H,   12'h000, 32'h00004000, 32'h0,        32'h1234F00D, 32'h00004000, 32'h0,        4'h0, 32'hFFFFF00D};
    vecs[9]  = '{5'd10, 1'b0, 3'b011, 12'h000, 32'h00000010, 32'h0,       32'hCAFEBABE, 32'h00000010, 32'h0,        4'h0, 32'hCAFEBABE};
    vecs[10] = '{5'd11, 1'b1, LS_H,  12'h000, 32'h00002002, 32'hFFFFABCD, 32'h0,        32'h00002002, 32'hABCD0000, 4'hC, 32'h0};
    vecs[11] = '{5'd12, 1'b0, LS_W,  12'h008, 32'hFFFFFFFC, 32'h0,        32'h11223344, 32'h00000004, 32'h0,        4'h0, 32'h11223344};

    for (int i = 0; i < 12; i++) begin
      exp_req.push_back('{vecs[i].e_addr, vecs[i].st, vecs[i].e_wdata, vecs[i].e_wmask, vecs[i].resp});
      exp_cpl.push_back('{vecs[i].rob, vecs[i].e_res});
      dispatch(make_op(vecs[i].rob, vecs[i].st, vecs[i].f3, vecs[i].imm, 1'b1, 5'd0,
                       vecs[i].base, 1'b1, 5'd0, vecs[i].sdata));
    end
    wait_drain("table");

    // store whose data arrives later on channel 1
    exp_req.push_back('{32'h00002002, 1'b1, 32'hABCD0000, 4'hC, 32'h0});
    exp_cpl.push_back('{5'd13, 32'h0});
    dispatch(make_op(5'd13, 1'b1, LS_H, 12'h000, 1'b1, 5'd0, 32'h00002002, 1'b0, 5'd7, 32'h0));
    for (int i = 0; i < 5; i++) begin
      check("sh_waits_for_data", bus.dc_req_valid, 1'b0);
      @(negedge clk);
    end
    set_bcast(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000ABCD);
    @(negedge clk);
    set_bcast(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    wait_drain("sh_late");

    // fill the queue with loads waiting on their base, then wake them two per cycle
    for (int i = 0; i < DEPTH; i++) begin
      exp_req.push_back('{32'h00005004 + 32'(i) * 32'h10, 1'b0, 32'h0, 4'h0, 32'hA0000000 | 32'(i)});
      exp_cpl.push_back('{5'(20 + i), 32'hA0000000 | 32'(i)});
      dispatch(make_op(5'(20 + i), 1'b0, LS_W, 12'h004, 1'b0, 5'(16 + i), 32'h0, 1'b1, 5'd0, 32'h0));
    end
    check("full_dispatch_ready", bus.dispatch_ready, 1'b0);
    check("full_no_request", bus.dc_req_valid, 1'b0);
    for (int k = 0; k < DEPTH / 2; k++) begin
      set_bcast(1'b1, 5'(16 + 2 * k), 32'h00005000 + 32'(2 * k) * 32'h10,
                1'b1, 5'(17 + 2 * k), 32'h00005000 + 32'(2 * k + 1) * 32'h10);
      @(negedge clk);
    end
    set_bcast(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    wait_drain("full_wrap");
    check("wrap_dispatch_ready", bus.dispatch_ready, 1'b1);
    check("wrap_head_ptr", 32'(dut.head_ptr), 32'(n_ops % (2 * DEPTH)));
    check("wrap_tail_ptr", 32'(dut.tail_ptr), 32'(n_ops % (2 * DEPTH)));

    // base arrives in the dispatch cycle; both channels match and channel 0 must win
    exp_req.push_back('{32'h00000050, 1'b0, 32'h0, 4'h0, 32'h13579BDF});
    exp_cpl.push_back('{5'd30, 32'h13579BDF});
    set_bcast(1'b1, 5'd3, 32'h00000040, 1'b1, 5'd3, 32'h00000080);
    dispatch(make_op(5'd30, 1'b0, LS_W, 12'h010, 1'b0, 5'd3, 32'h0, 1'b1, 5'd0, 32'h0));
    set_bcast(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    wait_drain("coincident");

    // reset while a load waits for its response
    resp_extra = 6;
    exp_req.push_back('{32'h00000100, 1'b0, 32'h0, 4'h0, 32'h00000055});
    dispatch(make_op(5'd9, 1'b0, LS_W, 12'h000, 1'b1, 5'd0, 32'h00000100, 1'b1, 5'd0, 32'h0));
    for (int g = 0; g < 100 && exp_req.size() != 0; g++) @(negedge clk);
    check("midrst_req_issued", 32'(exp_req.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_aL = 1'b0;
    @(negedge clk);
    check("midrst_dc_req_valid", bus.dc_req_valid, 1'b0);
    check("midrst_dispatch_ready", bus.dispatch_ready, 1'b1);
    rst_aL = 1'b1;
    resp_extra = 0;
    exp_req.delete();
    exp_cpl.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_completion", bus.lsu_bcast_valid, 1'b0);
    end
    exp_req.push_back('{32'h00000200, 1'b0, 32'h0, 4'h0, 32'h00000066});
    exp_cpl.push_back('{5'd1, 32'h00000066});
    dispatch(make_op(5'd1, 1'b0, LS_W, 12'h000, 1'b1, 5'd0, 32'h00000200, 1'b1, 5'd0, 32'h0));
    wait_drain("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
